frame_buffer_scheduler: RTL

- Sequences the double-buffered 1-bit-per-pixel frame buffer that feeds is_pixel to color_mapper.
- The front bank serves VGA reads. The back bank is cleared, then handed to the renderer for pixel writes.
- Banks swap only during vertical blank, so the displayed frame never tears.
- Sits between the rasterizer, the VGA controller and two single-port on-chip RAM banks.

---
 rtl/fb_pkg.sv | 30 +++
 rtl/frame_buffer_scheduler_if.sv | 24 ++
 rtl/fb_addr_calc.sv | 17 +
 rtl/frame_buffer_scheduler.sv | 129 ++++++++++++
 4 files changed

// File: rtl/fb_pkg.sv
// Shared types and address mapping for the double-buffered 1-bpp frame buffer.
package fb_pkg;

   localparam int H_RES    = 640;
   localparam int V_RES    = 480;
   localparam int FB_WORDS = H_RES * V_RES;
   localparam int ADDR_W   = 19;
   localparam int COORD_W  = 10;

   typedef enum logic [1:0] {
      IDLE,
      CLEAR,
      DRAW,
      WAIT_VSYNC
   } fb_state_t;

   // y*h_res + x as a sum of shifted copies of y; with a constant h_res this
   // folds to plain adders (y<<9 + y<<7 + x at 640).
   function automatic logic [31:0] pix_addr(input logic [COORD_W-1:0] x,
                                            input logic [COORD_W-1:0] y,
                                            input int                 h_res);
      logic [31:0] acc;
      acc = {22'd0, x};
      for (int i = 0; i < 16; i++) begin
         if (h_res[i]) acc = acc + ({22'd0, y} << i);
      end
      return acc;
   endfunction

endpackage

// File: rtl/frame_buffer_scheduler_if.sv
// Renderer-side handshake: back-buffer request, pixel writes and frame completion.
interface frame_buffer_scheduler_if;
   import fb_pkg::*;

   logic               frame_start;
   logic               draw_ready;
   logic               wr_req;
   logic [COORD_W-1:0] wr_x;
   logic [COORD_W-1:0] wr_y;
   logic               wr_color;
   logic               wr_ack;
   logic               frame_done;

   modport master (
      output frame_start, wr_req, wr_x, wr_y, wr_color, frame_done,
      input  draw_ready, wr_ack
   );

   modport slave (
      input  frame_start, wr_req, wr_x, wr_y, wr_color, frame_done,
      output draw_ready, wr_ack
   );

endinterface

// File: rtl/fb_addr_calc.sv
// Pixel coordinate to linear RAM address, plus a visible-area flag.
module fb_addr_calc #(
   parameter int H_RES  = fb_pkg::H_RES,
   parameter int V_RES  = fb_pkg::V_RES,
   parameter int ADDR_W = fb_pkg::ADDR_W
) (
   input  logic [9:0]        x,
   input  logic [9:0]        y,
   output logic [ADDR_W-1:0] addr,
   output logic              in_range
);
   import fb_pkg::*;

   assign addr     = ADDR_W'(pix_addr(x, y, H_RES));
   assign in_range = (int'(x) < H_RES) && (int'(y) < V_RES);

endmodule

// File: rtl/frame_buffer_scheduler.sv
// Double-buffered frame buffer sequencer: clears and fills the back bank while
// the front bank feeds VGA, swapping banks only during vertical blank.
module frame_buffer_scheduler #(
   parameter int H_RES  = fb_pkg::H_RES,
   parameter int V_RES  = fb_pkg::V_RES,
   parameter int ADDR_W = fb_pkg::ADDR_W
) (
   input  logic                      Clk,
   input  logic                      Reset,
   input  logic [9:0]                ReadX,
   input  logic [9:0]                ReadY,
   input  logic                      vsync_pulse,
   output logic                      is_pixel,
   frame_buffer_scheduler_if.slave   rnd,
   output logic                      front_sel,
   output logic [15:0]               frame_count,
   output logic [ADDR_W-1:0]         mem0_addr,
   output logic                      mem0_we,
   output logic                      mem0_wdata,
   input  logic                      mem0_rdata,
   output logic [ADDR_W-1:0]         mem1_addr,
   output logic                      mem1_we,
   output logic                      mem1_wdata,
   input  logic                      mem1_rdata
);
   import fb_pkg::*;

   localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(H_RES * V_RES - 1);

   fb_state_t         state_q, state_d;
   logic [ADDR_W-1:0] clr_addr_q, clr_addr_d;
   logic              front_sel_d;
   logic [15:0]       frame_count_d;

   logic [ADDR_W-1:0] rd_addr, wr_addr, back_addr;
   logic              rd_in_range, wr_in_range;
   logic              back_we, back_wdata;
   logic              rd_in_range_q, rd_sel_q;

   fb_addr_calc #(.H_RES(H_RES), .V_RES(V_RES), .ADDR_W(ADDR_W)) u_rd_calc (
      .x        (ReadX),
      .y        (ReadY),
      .addr     (rd_addr),
      .in_range (rd_in_range)
   );

   fb_addr_calc #(.H_RES(H_RES), .V_RES(V_RES), .ADDR_W(ADDR_W)) u_wr_calc (
      .x        (rnd.wr_x),
      .y        (rnd.wr_y),
      .addr     (wr_addr),
      .in_range (wr_in_range)
   );

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples the pre-edge values regardless of statement order.
   always_ff @(posedge Clk) begin
      if (Reset) begin
         state_q       <= IDLE;
         clr_addr_q    <= '0;
         front_sel     <= 1'b0;
         frame_count   <= '0;
         rd_in_range_q <= 1'b0;
         rd_sel_q      <= 1'b0;
      end else begin
         state_q       <= state_d;
         clr_addr_q    <= clr_addr_d;
         front_sel     <= front_sel_d;
         frame_count   <= frame_count_d;
         rd_in_range_q <= rd_in_range;
         rd_sel_q      <= front_sel;
      end
   end

   // NOTE: every output of this block gets a default first, so no path through
   // the case statement can leave a value held and infer a latch.
   always_comb begin
      state_d        = state_q;
      clr_addr_d     = clr_addr_q;
      front_sel_d    = front_sel;
      frame_count_d  = frame_count;
      back_addr      = wr_addr;
      back_we        = 1'b0;
      back_wdata     = 1'b0;
      rnd.draw_ready = 1'b0;
      rnd.wr_ack     = 1'b0;

      case (state_q)
         IDLE: begin
            if (rnd.frame_start) begin
               state_d    = CLEAR;
               clr_addr_d = '0;
            end
         end
         CLEAR: begin
            back_addr = clr_addr_q;
            back_we   = 1'b1;
            if (clr_addr_q == LAST_ADDR) state_d    = DRAW;
            else                         clr_addr_d = clr_addr_q + 1'b1;
         end
         DRAW: begin
            rnd.draw_ready = 1'b1;
            rnd.wr_ack     = rnd.wr_req;
            // Off-screen writes are acknowledged but clipped.
            back_we        = rnd.wr_req & wr_in_range;
            back_wdata     = rnd.wr_color;
            if (rnd.frame_done) state_d = WAIT_VSYNC;
         end
         WAIT_VSYNC: begin
            if (vsync_pulse) begin
               front_sel_d   = ~front_sel;
               frame_count_d = frame_count + 16'd1;
               state_d       = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // The front bank only ever sees the read address with its write disabled.
   assign mem0_addr  = front_sel ? back_addr  : rd_addr;
   assign mem0_we    = front_sel ? back_we    : 1'b0;
   assign mem0_wdata = front_sel ? back_wdata : 1'b0;
   assign mem1_addr  = front_sel ? rd_addr    : back_addr;
   assign mem1_we    = front_sel ? 1'b0       : back_we;
   assign mem1_wdata = front_sel ? 1'b0       : back_wdata;

   assign is_pixel = rd_in_range_q & (rd_sel_q ? mem1_rdata : mem0_rdata);

endmodule
